// File: rtl/simon_io_ctrl.sv
// -----------------------------------------------------------------------------
// simon_io_ctrl
//
// Byte-wide host front-end for the bit-serial Simon-128/128 core. Collects a
// plaintext block from the host byte port, drives the core through its key
// load, plaintext load and encrypt phases, captures the serial ciphertext and
// hands it back to the host one byte at a time.
//
// Ports:
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   byte_in*          host plaintext byte port (valid/ready)
//   byte_out*         host ciphertext byte port (valid/ready)
//   busy              high while a block is being loaded, run or drained
//   error             sticky: RUN timeout or a ciphertext stream cut short
//   core_data_in      serial bit to the core
//   core_data_rdy     core command: 00 idle, 10 key bit, 01 pt bit, 11 encrypt
//   core_cipher_out   serial ciphertext bit from the core
//   core_valid        core is presenting a ciphertext bit this cycle
//   state_dbg         current FSM state, for checkers and debug
//
// Handshake rule (both host ports): a byte moves on a rising edge where valid
// and ready are both 1. Ready/valid here depend only on the FSM state, never on
// the partner's signal, and byte_out is held stable while valid=1 and ready=0.
//
// Bit order is LSB-first everywhere: host byte 0 is block bits [7:0], plaintext
// bit i goes to the core on LOAD_PT cycle i, the first ciphertext bit captured
// becomes bit 0, and the first output byte is ciphertext bits [7:0].
// -----------------------------------------------------------------------------
module simon_io_ctrl #(
    parameter int BLOCK_BITS = 128,
    parameter int KEY_BITS   = 128,
    parameter int TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_in_valid,
    output logic       byte_in_ready,
    output logic [7:0] byte_out,
    output logic       byte_out_valid,
    input  logic       byte_out_ready,
    output logic       busy,
    output logic       error,
    output logic       core_data_in,
    output logic [1:0] core_data_rdy,
    input  logic       core_cipher_out,
    input  logic       core_valid,
    output logic [2:0] state_dbg
);

    localparam int NBYTES    = BLOCK_BITS / 8;
    localparam int MAX_PHASE = (KEY_BITS > BLOCK_BITS) ? KEY_BITS : BLOCK_BITS;
    localparam int BIT_W     = $clog2(MAX_PHASE);
    localparam int BYTE_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TO_W      = $clog2(TIMEOUT + 1);

    localparam logic [BIT_W-1:0]  KEY_LAST  = BIT_W'(KEY_BITS - 1);
    localparam logic [BIT_W-1:0]  BLK_LAST  = BIT_W'(BLOCK_BITS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_LOAD_KEY = 3'd2,
        S_LOAD_PT  = 3'd3,
        S_RUN      = 3'd4,
        S_CAPTURE  = 3'd5,
        S_DRAIN    = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [BLOCK_BITS-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BYTE_W-1:0]     byte_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic                  error_q;

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        byte_in_ready  = 1'b0;
        byte_out_valid = 1'b0;
        byte_out       = 8'h00;
        core_data_rdy  = 2'b00;
        core_data_in   = 1'b0;
        busy           = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy          = 1'b0;
                byte_in_ready = 1'b1;
                if (byte_in_valid) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                busy          = 1'b0;
                byte_in_ready = 1'b1;
                if (byte_in_valid && byte_cnt == BYTE_LAST) state_d = S_LOAD_KEY;
            end
            S_LOAD_KEY: begin
                // The core hard-wires a zero key; we still clock KEY_BITS key cycles.
                core_data_rdy = 2'b10;
                if (bit_cnt == KEY_LAST) state_d = S_LOAD_PT;
            end
            S_LOAD_PT: begin
                core_data_rdy = 2'b01;
                core_data_in  = shreg[0];
                if (bit_cnt == BLK_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                core_data_rdy = 2'b11;
                if (core_valid)              state_d = S_CAPTURE;
                else if (to_cnt == TO_LAST)  state_d = S_IDLE;
            end
            S_CAPTURE: begin
                core_data_rdy = 2'b11;
                // The core streams the ciphertext without gaps; a gap means a
                // broken block, so it is dropped rather than drained.
                if (!core_valid)                state_d = S_IDLE;
                else if (bit_cnt == BLK_LAST)   state_d = S_DRAIN;
            end
            S_DRAIN: begin
                byte_out_valid = 1'b1;
                byte_out       = shreg[7:0];
                if (byte_out_ready && byte_cnt == BYTE_LAST) state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Datapath: shared shift register and phase counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            to_cnt   <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (byte_in_valid) begin
                        // Bytes enter at the top and walk down, so after the
                        // last byte the first one sits in bits [7:0].
                        shreg    <= {byte_in, shreg[BLOCK_BITS-1:8]};
                        byte_cnt <= BYTE_W'(1);
                        error_q  <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    bit_cnt <= '0;
                    if (byte_in_valid) begin
                        shreg    <= {byte_in, shreg[BLOCK_BITS-1:8]};
                        byte_cnt <= byte_cnt + BYTE_W'(1);
                    end
                end
                S_LOAD_KEY: begin
                    bit_cnt <= (bit_cnt == KEY_LAST) ? '0 : bit_cnt + BIT_W'(1);
                end
                S_LOAD_PT: begin
                    shreg   <= {1'b0, shreg[BLOCK_BITS-1:1]};
                    bit_cnt <= (bit_cnt == BLK_LAST) ? '0 : bit_cnt + BIT_W'(1);
                    to_cnt  <= '0;
                end
                S_RUN: begin
                    if (core_valid) begin
                        // Ciphertext enters at the top too, so the first
                        // captured bit ends up as bit 0.
                        shreg   <= {core_cipher_out, shreg[BLOCK_BITS-1:1]};
                        bit_cnt <= BIT_W'(1);
                    end else if (to_cnt == TO_LAST) begin
                        error_q <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_CAPTURE: begin
                    byte_cnt <= '0;
                    if (core_valid) begin
                        shreg   <= {core_cipher_out, shreg[BLOCK_BITS-1:1]};
                        bit_cnt <= (bit_cnt == BLK_LAST) ? '0 : bit_cnt + BIT_W'(1);
                    end else begin
                        error_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (byte_out_ready) begin
                        shreg    <= {8'h00, shreg[BLOCK_BITS-1:8]};
                        byte_cnt <= byte_cnt + BYTE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign error     = error_q;
    assign state_dbg = state_q;

endmodule
